// File: rtl/uart_pkg.sv
// uart_pkg: shared UART request-size and serializer-state types plus size decoding
package uart_pkg;

    typedef enum logic [1:0] {
        UART_SZ_B = 2'd0,
        UART_SZ_H = 2'd1,
        UART_SZ_W = 2'd2
    } uart_size_t;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } uart_ser_state_t;

    // Index of the final byte lane for a request size; size 3 is treated as a word.
    function automatic logic [1:0] size_to_last_idx(input logic [1:0] size);
        return size == UART_SZ_B ? 2'd0 : size == UART_SZ_H ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: splits 1/2/4-byte core requests into bytes for the UART transmit FIFO
// Ports:
//   clk, rstn              core clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_data payload, req_size 0=B 1=H 2/3=W
//   tx_wr_en/tx_din        byte write into the transmit FIFO, stalled by tx_full
//   busy                   a request is partially sent
//   sent_count             running total of bytes written (wraps)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        tx_wr_en,
    output logic [7:0]  tx_din,
    input  logic        tx_full,
    output logic        busy,
    output logic [31:0] sent_count
);

    uart_ser_state_t state;
    logic [31:0]     data;
    logic [1:0]      last_idx;
    logic [1:0]      idx;
    logic [1:0]      lane;
    logic            last;
    logic            accept;

    assign last      = idx == last_idx;
    assign busy      = state == SER_SEND;
    assign tx_wr_en  = busy && !tx_full;
    // Ready during the final unstalled byte so back-to-back requests leave no bubble.
    assign req_ready = !busy || (last && !tx_full);
    assign accept    = req_valid && req_ready;
    assign lane      = MSB_FIRST ? last_idx - idx : idx;
    assign tx_din    = data[{lane, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= SER_IDLE;
            data       <= '0;
            last_idx   <= '0;
            idx        <= '0;
            sent_count <= '0;
        end else begin
            if (accept) begin
                state    <= SER_SEND;
                data     <= req_data;
                last_idx <= size_to_last_idx(req_size);
                idx      <= '0;
            end else if (tx_wr_en && last) begin
                state <= SER_IDLE;
            end else if (tx_wr_en) begin
                idx <= idx + 2'd1;
            end
            if (tx_wr_en)
                sent_count <= sent_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench driving LSB-first and MSB-first serializers in lockstep
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        tx_full = 1'b0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        rdy0, rdy1, wr0, wr1, busy0, busy1;
    logic [7:0]  din0, din1, e0, e1;
    logic [31:0] cnt0, cnt1;
    logic [31:0] exp_cnt = '0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt0 = 0;
    int          wr_cnt1 = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy0),
        .req_data(req_data), .req_size(req_size), .tx_wr_en(wr0), .tx_din(din0),
        .tx_full(tx_full), .busy(busy0), .sent_count(cnt0)
    );

    uart_tx_serializer #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy1),
        .req_data(req_data), .req_size(req_size), .tx_wr_en(wr1), .tx_din(din1),
        .tx_full(tx_full), .busy(busy1), .sent_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] sz);
        int n;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            q0.push_back(d[8*i +: 8]);
            q1.push_back(d[8*(n-1-i) +: 8]);
        end
        exp_cnt = exp_cnt + 32'(n);
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] sz, output int waited);
        req_valid = 1'b1;
        req_data  = d;
        req_size  = sz;
        push_exp(d, sz);
        waited = 0;
        @(negedge clk);
        while (!rdy0 && waited < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        chk("accept", {31'b0, rdy0}, 32'd1);
        chk("ready_match", {31'b0, rdy1}, {31'b0, rdy0});
        @(posedge clk); #1;
    endtask

    task automatic expect_wr(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("wr_en0", {31'b0, wr0}, 32'd1);
            chk("wr_en1", {31'b0, wr1}, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_wr0", {31'b0, wr0}, 32'd0);
        chk("idle_busy0", {31'b0, busy0}, 32'd0);
        chk("idle_busy1", {31'b0, busy1}, 32'd0);
        chk("count0", cnt0, exp_cnt);
        chk("count1", cnt1, exp_cnt);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (wr0 === 1'b1) begin
            if (q0.size() == 0) chk("unexp_wr0", {31'b0, wr0}, 32'd0);
            else begin
                e0 = q0.pop_front();
                chk("byte0", {24'b0, din0}, {24'b0, e0});
            end
            wr_cnt0++;
        end
        if (wr1 === 1'b1) begin
            if (q1.size() == 0) chk("unexp_wr1", {31'b0, wr1}, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("byte1", {24'b0, din1}, {24'b0, e1});
            end
            wr_cnt1++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int base;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, rdy0}, 32'd1);
        chk("rst_wr", {31'b0, wr0}, 32'd0);
        chk("rst_din0", {24'b0, din0}, 32'd0);
        chk("rst_din1", {24'b0, din1}, 32'd0);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_count", cnt0, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        send(32'h4433_2211, 2'd2, w);
        req_valid = 1'b0;
        expect_wr(4);
        idle_chk();

        base = wr_cnt0;
        send(32'h4433_2211, 2'd3, w);
        req_valid = 1'b0;
        expect_wr(4);
        idle_chk();
        chk("size3_writes", 32'(wr_cnt0 - base), 32'd4);

        send(32'h0000_BEEF, 2'd1, w);
        req_valid = 1'b0;
        expect_wr(2);
        idle_chk();
        send(32'hFFFF_FF5A, 2'd0, w);
        req_valid = 1'b0;
        expect_wr(1);
        idle_chk();

        base = wr_cnt0;
        send(32'h01, 2'd0, w);
        send(32'h02, 2'd0, w);
        chk("b2b_wait2", 32'(w), 32'd0);
        send(32'h03, 2'd0, w);
        chk("b2b_wait3", 32'(w), 32'd0);
        req_valid = 1'b0;
        expect_wr(1);
        idle_chk();
        chk("b2b_writes", 32'(wr_cnt0 - base), 32'd3);

        base = wr_cnt0;
        send(32'h8877_6655, 2'd2, w);
        req_valid = 1'b0;
        expect_wr(2);
        tx_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_wr", {31'b0, wr0}, 32'd0);
            chk("stall_ready", {31'b0, rdy0}, 32'd0);
            chk("stall_busy", {31'b0, busy0}, 32'd1);
            chk("stall_din0", {24'b0, din0}, 32'h77);
            chk("stall_din1", {24'b0, din1}, 32'h66);
            @(posedge clk); #1;
        end
        tx_full = 1'b0;
        expect_wr(2);
        idle_chk();
        chk("stall_writes", 32'(wr_cnt0 - base), 32'd4);

        send(32'h0000_A1B2, 2'd1, w);
        req_valid = 1'b0;
        expect_wr(1);
        tx_full   = 1'b1;
        req_valid = 1'b1;
        req_data  = 32'hC3;
        req_size  = 2'd0;
        push_exp(32'hC3, 2'd0);
        @(negedge clk);
        chk("lastfull_wr", {31'b0, wr0}, 32'd0);
        chk("lastfull_ready", {31'b0, rdy0}, 32'd0);
        chk("lastfull_busy", {31'b0, busy0}, 32'd1);
        @(posedge clk); #1;
        tx_full = 1'b0;
        @(negedge clk);
        chk("lastfree_wr", {31'b0, wr0}, 32'd1);
        chk("lastfree_ready", {31'b0, rdy0}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        expect_wr(1);
        idle_chk();

        send(32'h0D0C_0B0A, 2'd2, w);
        req_valid = 1'b0;
        expect_wr(2);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_wr0", {31'b0, wr0}, 32'd0);
        chk("midrst_wr1", {31'b0, wr1}, 32'd0);
        chk("midrst_busy", {31'b0, busy0}, 32'd0);
        chk("midrst_ready", {31'b0, rdy0}, 32'd1);
        chk("midrst_count", cnt0, 32'd0);
        q0.delete();
        q1.delete();
        exp_cnt = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        send(32'h0D0C_0B0A, 2'd2, w);
        req_valid = 1'b0;
        expect_wr(4);
        idle_chk();

        force dut0.sent_count = 32'hFFFF_FFFF;
        force dut1.sent_count = 32'hFFFF_FFFF;
        #1;
        release dut0.sent_count;
        release dut1.sent_count;
        exp_cnt = 32'hFFFF_FFFF;
        send(32'h77, 2'd0, w);
        req_valid = 1'b0;
        expect_wr(1);
        idle_chk();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Upstream feeder for the UART transmit unit: accepts 1-, 2- or 4-byte requests from the core over a valid/ready handshake and splits each one into bytes. It writes those bytes into the transmit unit's byte FIFO (`wr_en`/`din`/`full`), one byte per cycle, and stalls while the FIFO reports full. It lives entirely in the core clock domain; the CDC to the UART clock stays inside the transmit unit.

## Interface
- `MSB_FIRST`, default 0 — 0: least-significant byte sent first; 1: most-significant byte of the request sent first.
- `clk`  in  1  core clock; every register updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  serializer can take a request this cycle.
- `req_data`  in  32  payload; only the low 8 or 16 bits are used for byte or half requests.
- `req_size`  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = treated as 4 bytes.
- `tx_wr_en`  out  1  byte write strobe to the transmit FIFO.
- `tx_din`  out  8  byte to the transmit FIFO.
- `tx_full`  in  1  transmit FIFO full.
- `busy`  out  1  a request is partially sent.
- `sent_count`  out  32  running total of bytes written to the FIFO.

## Operation
- Two-state FSM: IDLE and SEND.
- Request accepted on any edge where `req_valid && req_ready`.
- On acceptance the block registers:
  - the payload,
  - `last_idx` (0, 1 or 3),
  - `idx = 0`.
- On acceptance the state moves to SEND.
- In SEND:
  - `tx_wr_en = !tx_full` (combinational).
  - `tx_din` is selected by `idx`:
    - `MSB_FIRST=0`: byte `idx` is `data[8*idx +: 8]`.
    - `MSB_FIRST=1`: byte `idx` is `data[8*(last_idx-idx) +: 8]`.
  - On each edge with `tx_wr_en=1`, `idx` increments and `sent_count` increments.
  - `sent_count` wraps modulo 2^32.
- Last byte: the write with `idx == last_idx`. The state then returns to IDLE unless a new request is accepted on the same edge.
- `req_ready = (state==IDLE) || (state==SEND && idx==last_idx && !tx_full)`.
  - This lets back-to-back requests run with no bubble.
  - The next request's payload is loaded, `idx` is reset to 0, and the state stays SEND.
- `busy = (state==SEND)`.
- In IDLE: `tx_wr_en = 0`, and `tx_din` holds the last registered value (don't-care).
- `tx_full` is only obeyed combinationally. The block never writes in a cycle where `tx_full=1`, so no byte is lost or duplicated.
- `req_data` and `req_size` are only sampled on the accepting edge; changing them afterwards has no effect.
- A `req_size=3` request behaves identically to `req_size=2`.

## Timing
- Reset values: state IDLE, `idx` 0, payload 0, `sent_count` 0.
- During reset, outputs are `req_ready=1`, `tx_wr_en=0`, `tx_din=0`, `busy=0`.
- Latency: request accepted at edge k → first byte has `tx_wr_en=1` in the cycle after edge k (written at edge k+1) if `tx_full=0`.
- An N-byte request with the FIFO never full occupies exactly N cycles of `tx_wr_en`.
- Throughput: 1 byte/cycle sustained, including across request boundaries.
- `tx_full` high for M cycles mid-request inserts exactly M stall cycles. During the stall:
  - `idx`, payload and `tx_din` hold.
  - `req_ready=0`.
- `tx_full` and the last byte in the same cycle: no write, no acceptance, state stays SEND.
- Reset asserted mid-request:
  - immediate return to IDLE;
  - remaining bytes are dropped;
  - `tx_wr_en` drops within the same cycle (asynchronous);
  - `sent_count` is cleared.
- No combinational path from `req_valid` to `req_ready`.
- The only combinational input-to-output paths are `tx_full` → `tx_wr_en` and `tx_full` → `req_ready`.

## Structure
- Shared package `uart_pkg` holds:
  - `typedef enum logic [1:0] {UART_SZ_B=0, UART_SZ_H=1, UART_SZ_W=2} uart_size_t`;
  - the state enum `uart_ser_state_t {SER_IDLE, SER_SEND}`.
- The size-to-`last_idx` mapping is a function in `uart_pkg`, reused by the receive-side packer.
- No sub-module. The byte-lane mux, FSM and counter stay inline in one module.
- Intended top-level wiring: `tx_wr_en`/`tx_din`/`tx_full` connect to the transmit unit's `wr_en`/`din`/`full`.

## Test plan
- Reset, `req_valid=1`, size 2, data 0x44332211, `tx_full=0` → writes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; `sent_count=4`; `busy` falls after the 4th write.
- `MSB_FIRST=1`, size 1, data 0x0000BEEF → writes 0xBE then 0xEF; a size 0 request with data 0x5A → writes only 0x5A.
- Back-to-back size-0 requests 0x01, 0x02, 0x03 held valid → three writes on three consecutive cycles; `req_ready` stays high throughout.
- Size 2 request with `tx_full` forced high for 5 cycles after the 2nd byte → no writes and `req_ready=0` during the stall; bytes 3–4 then follow in order; total 4 writes.
- `tx_full` high on the last-byte cycle while the next request is valid → neither a write nor an acceptance that cycle; both happen on the first cycle `tx_full` is low.
- `rstn` pulsed low after 2 bytes of a word → `tx_wr_en` is 0 immediately; `sent_count=0`; the next request starts from byte 0. Also preload `sent_count` to 0xFFFFFFFF and send 1 byte → `sent_count` wraps to 0.
